trigger_fanout: RTL and testbench
=================================

Name: trigger_fanout

Overview:
- Downstream consumer of the experiment sequencer's output_trigger.
- On each accepted rising edge of the trigger, drives N_CH detector/digitizer trigger lines, each with its own programmable delay and pulse width.
- Follows each burst with a holdoff window, during which further edges are rejected and counted as missed.
- Sits between the experiment FSM and the front-panel trigger outputs, in the same clock domain (10 ns period).

Parameters:
- N_CH, 4, number of output trigger channels.
- CNT_W, 24, width of each delay, width and holdoff field, in clock cycles.
- STAT_W, 16, width of the trigger and missed-trigger statistic counters.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- trigger_in  in  1  level from the experiment FSM, synchronous to clock; rising edge = trigger request.
- arm  in  1  when low, trigger edges are ignored (not accepted, not counted).
- delay_cfg  in  N_CH*CNT_W  per-channel delay; channel i = bits [i*CNT_W +: CNT_W].
- width_cfg  in  N_CH*CNT_W  per-channel pulse width in cycles; 0 = channel disabled.
- holdoff_cfg  in  CNT_W  dead time after the last channel pulse ends.
- ch_out  out  N_CH  registered trigger pulses.
- busy  out  1  high in RUN and HOLDOFF.
- trig_count  out  STAT_W  accepted triggers; saturating.
- missed_count  out  STAT_W  edges rejected while busy; saturating.

Behaviour:
Reset:
- Asynchronous reset gives ch_out=0, busy=0, trig_count=0, missed_count=0, state=IDLE, edge register=0.
- Reset asserted mid-burst drops all ch_out low immediately (asynchronously). No pulse resumes after release.
- After reset release, trigger_in already high is not an edge. A 0->1 transition is required.

Edge detection:
- edge = trigger_in & ~trigger_in_q, where trigger_in_q is trigger_in registered every cycle in every state.
- Call the clock edge at which edge is sampled cycle T.

States:
- IDLE, busy=0.
  - edge & arm: latch delay_cfg, width_cfg and holdoff_cfg into shadow registers, trig_count++, go to RUN.
  - edge & ~arm: no action.
- RUN, busy=1.
  - Elapsed counter E is CNT_W+1 bits so that delay+width cannot overflow.
  - ch_out[i] is high exactly on clock cycles T+1+d_i through T+d_i+w_i, i.e. w_i cycles starting d_i+1 cycles after T.
  - d_i=0 means the pulse starts the cycle after T.
  - w_i=0 means ch_out[i] stays low for the whole burst.
  - RUN exits on the cycle after the latest pulse end, max(d_i+w_i).
  - If all w_i=0, RUN lasts exactly 1 cycle.
  - holdoff=0: go directly to IDLE. Otherwise go to HOLDOFF.
- HOLDOFF, busy=1.
  - Counts holdoff cycles, then returns to IDLE; all ch_out low.
  - The first cycle in IDLE may accept a new edge.

Edge handling and arm while busy:
- Edges in RUN or HOLDOFF: missed_count++ if arm=1; never restarts, extends or aborts the burst.
- arm deassert while busy: the burst completes normally.

Configuration and counters:
- Config changes while busy have no effect until the next accepted trigger; the shadow registers are used.
- Both statistic counters saturate at 2^STAT_W-1 and never wrap.
- Counters are cleared only by reset.
- A trigger held high for many cycles counts as one edge.

Test Plan:
- Single trigger: arm=1, N_CH=4, d={0,5,10,2}, w={1,3,4,0}, holdoff=0, trigger_in high at cycle 10.
  - ch0 high cycle 11.
  - ch1 high 16-18.
  - ch2 high 21-24.
  - ch3 never high.
  - busy high 11-24, low at 25.
  - trig_count=1.
- Holdoff rejection: same config with holdoff=20; second edge during RUN and third edge during HOLDOFF.
  - No extra pulses.
  - missed_count=2, trig_count=1.
  - An edge at the first IDLE cycle after holdoff is accepted (trig_count=2).
- Disarmed: arm=0, three trigger edges.
  - ch_out stays 0, busy stays 0, both counters stay 0.
  - Set arm=1 while trigger_in is held high: no trigger until the next 0->1 transition.
- Shadowing: change delay_cfg ch1 from 5 to 50 at cycle 13 of the single-trigger scenario.
  - The current burst keeps ch1 at 16-18.
  - The next burst uses delay 50.
- Reset mid-pulse: assert reset during ch2 high (cycle 22).
  - All ch_out and busy go 0 before the next clock edge.
  - Counters read 0.
  - After release, no residual pulses with trigger_in held high.
- Saturation and wide values: force 65535 accepted triggers (STAT_W=16), then one more; trig_count stays 65535.
  - With d=2^24-1, w=2^24-1: the pulse ends at T+2^25-2 without overflow.

Source files
------------

// File: rtl/trigger_fanout.sv
// rtl/trigger_fanout.sv - per-channel delayed trigger pulse generator with holdoff and statistics
module trigger_fanout #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 24,
  parameter int STAT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   trigger_in,
  input  logic                   arm,
  input  logic [N_CH*CNT_W-1:0]  delay_cfg,
  input  logic [N_CH*CNT_W-1:0]  width_cfg,
  input  logic [CNT_W-1:0]       holdoff_cfg,
  output logic [N_CH-1:0]        ch_out,
  output logic                   busy,
  output logic [STAT_W-1:0]      trig_count,
  output logic [STAT_W-1:0]      missed_count
);

  localparam int EW = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLDOFF} state_t;

  state_t                     state_q;
  logic                       trig_q;
  logic                       primed_q;
  logic [EW-1:0]              e_q;
  logic [EW-1:0]              m_q;
  logic [CNT_W-1:0]           h_q;
  logic [CNT_W-1:0]           hold_q;
  logic [N_CH-1:0][EW-1:0]    start_q;
  logic [N_CH-1:0][EW-1:0]    end_q;
  logic [N_CH-1:0]            ch_q;
  logic                       busy_q;
  logic [STAT_W-1:0]          trig_cnt_q;
  logic [STAT_W-1:0]          miss_cnt_q;

  logic                       trig_edge;
  logic [EW-1:0]              e_next;
  logic [EW-1:0]              cfg_max;
  logic [N_CH-1:0][EW-1:0]    cfg_start;
  logic [N_CH-1:0][EW-1:0]    cfg_end;
  logic [N_CH-1:0]            acc_pat;
  logic [N_CH-1:0]            run_pat;

  // primed_q keeps a level that is already high at reset release from looking like an edge
  assign trig_edge = trigger_in & ~trig_q & primed_q;
  assign e_next    = e_q + EW'(1);

  always_comb begin
    cfg_max   = '0;
    cfg_start = '0;
    cfg_end   = '0;
    acc_pat   = '0;
    run_pat   = '0;
    for (int i = 0; i < N_CH; i++) begin
      cfg_start[i] = EW'(delay_cfg[i*CNT_W +: CNT_W]);
      cfg_end[i]   = cfg_start[i] + EW'(width_cfg[i*CNT_W +: CNT_W]);
      acc_pat[i]   = (cfg_start[i] == '0) && (cfg_end[i] != '0);
      run_pat[i]   = (e_next > start_q[i]) && (e_next <= end_q[i]);
      if ((width_cfg[i*CNT_W +: CNT_W] != '0) && (cfg_end[i] > cfg_max))
        cfg_max = cfg_end[i];
    end
  end

  // e_q holds the burst-relative index of the cycle currently shown on ch_out
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      trig_q     <= 1'b0;
      primed_q   <= 1'b0;
      e_q        <= '0;
      m_q        <= '0;
      h_q        <= '0;
      hold_q     <= '0;
      start_q    <= '0;
      end_q      <= '0;
      ch_q       <= '0;
      busy_q     <= 1'b0;
      trig_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      trig_q   <= trigger_in;
      primed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (trig_edge && arm) begin
            start_q <= cfg_start;
            end_q   <= cfg_end;
            m_q     <= cfg_max;
            hold_q  <= holdoff_cfg;
            e_q     <= EW'(1);
            ch_q    <= acc_pat;
            busy_q  <= 1'b1;
            state_q <= RUN;
            if (trig_cnt_q != '1)
              trig_cnt_q <= trig_cnt_q + STAT_W'(1);
          end
        end
        RUN: begin
          if (trig_edge && arm && (miss_cnt_q != '1))
            miss_cnt_q <= miss_cnt_q + STAT_W'(1);
          if (e_q >= m_q) begin
            ch_q <= '0;
            e_q  <= '0;
            if (hold_q == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= HOLDOFF;
              h_q     <= CNT_W'(1);
            end
          end else begin
            e_q  <= e_next;
            ch_q <= run_pat;
          end
        end
        HOLDOFF: begin
          if (trig_edge && arm && (miss_cnt_q != '1))
            miss_cnt_q <= miss_cnt_q + STAT_W'(1);
          if (h_q >= hold_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            h_q <= h_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ch_q    <= '0;
        end
      endcase
    end
  end

  assign ch_out       = ch_q;
  assign busy         = busy_q;
  assign trig_count   = trig_cnt_q;
  assign missed_count = miss_cnt_q;

endmodule

// File: tb/tb_trigger_fanout.sv
// tb/tb_trigger_fanout.sv - table-driven scoreboard bench for trigger_fanout
module tb_trigger_fanout;
  localparam int N  = 4;
  localparam int CW = 24;
  localparam int SW = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic trigger_in, arm;
  logic [N*CW-1:0] delay_cfg, width_cfg;
  logic [CW-1:0] holdoff_cfg;
  logic [N-1:0] ch_out;
  logic busy;
  logic [SW-1:0] trig_count, missed_count;

  logic s_trig, s_arm;
  logic [15:0] s_delay, s_width;
  logic [3:0] s_hold;
  logic [3:0] s_ch;
  logic s_busy;
  logic [2:0] s_tc, s_mc;

  always #5 clock = ~clock;

  trigger_fanout #(.N_CH(N), .CNT_W(CW), .STAT_W(SW)) dut (
    .clock(clock), .reset(reset), .trigger_in(trigger_in), .arm(arm),
    .delay_cfg(delay_cfg), .width_cfg(width_cfg), .holdoff_cfg(holdoff_cfg),
    .ch_out(ch_out), .busy(busy), .trig_count(trig_count), .missed_count(missed_count)
  );

  // narrow instance: overflow of delay+width and counter saturation in few cycles
  trigger_fanout #(.N_CH(4), .CNT_W(4), .STAT_W(3)) u_sat (
    .clock(clock), .reset(reset), .trigger_in(s_trig), .arm(s_arm),
    .delay_cfg(s_delay), .width_cfg(s_width), .holdoff_cfg(s_hold),
    .ch_out(s_ch), .busy(s_busy), .trig_count(s_tc), .missed_count(s_mc)
  );

  typedef struct {
    logic [3:0][7:0] d;
    logic [3:0][7:0] w;
    int h;
    bit arm;
    int x1, x2, hold, chg, chg_d1, arm_off, gap;
  } vec_t;

  typedef struct packed {
    logic [3:0] ch;
    logic busy;
  } exp_t;

  vec_t vt[9];
  exp_t sb[$];
  int n_vec = 0;
  int n_mis = 0;
  int exp_trig = 0;
  int exp_missed = 0;

  function automatic vec_t mk(input logic [3:0][7:0] d, input logic [3:0][7:0] w, input int h,
                              input bit a, input int x1, input int x2, input int hold,
                              input int chg, input int chg_d1, input int arm_off, input int gap);
    vec_t v;
    v.d = d; v.w = w; v.h = h; v.arm = a; v.x1 = x1; v.x2 = x2; v.hold = hold;
    v.chg = chg; v.chg_d1 = chg_d1; v.arm_off = arm_off; v.gap = gap;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    exp_t e;
    int m, total, len;
    v = vt[idx];
    for (int i = 0; i < N; i++) begin
      delay_cfg[i*CW +: CW] = CW'(v.d[i]);
      width_cfg[i*CW +: CW] = CW'(v.w[i]);
    end
    holdoff_cfg = CW'(v.h);
    arm = v.arm;
    trigger_in = 1'b1;
    m = 0;
    for (int i = 0; i < N; i++)
      if (v.w[i] != 0 && int'(v.d[i]) + int'(v.w[i]) > m) m = int'(v.d[i]) + int'(v.w[i]);
    total = v.arm ? (((m == 0) ? 1 : m) + v.h) : 0;
    len = total + 1;
    if (v.hold + 1 > len) len = v.hold + 1;
    if (v.x1 + 2 > len) len = v.x1 + 2;
    if (v.x2 + 2 > len) len = v.x2 + 2;
    if (!v.arm && len < 12) len = 12;
    for (int k = 1; k <= len; k++) begin
      e.busy = (k <= total);
      for (int i = 0; i < N; i++)
        e.ch[i] = (k <= total) && (k > int'(v.d[i])) && (k <= int'(v.d[i]) + int'(v.w[i]));
      sb.push_back(e);
    end
    if (v.arm) exp_trig++;
    if (v.x1 != 0 && v.x1 <= total && (v.arm_off == 0 || v.x1 < v.arm_off)) exp_missed++;
    if (v.x2 != 0 && v.x2 <= total && (v.arm_off == 0 || v.x2 < v.arm_off)) exp_missed++;
    for (int k = 1; k <= len; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      check($sformatf("v%0d k%0d ch_out", idx, k), 64'(ch_out), 64'(e.ch));
      check($sformatf("v%0d k%0d busy", idx, k), 64'(busy), 64'(e.busy));
      trigger_in = (k < v.hold) || (k == v.x1) || (k == v.x2);
      if (v.arm_off != 0 && k >= v.arm_off) arm = 1'b0;
      if (k == v.chg) delay_cfg[1*CW +: CW] = CW'(v.chg_d1);
    end
    if (v.gap > 0) begin
      trigger_in = 1'b0;
      repeat (v.gap) @(negedge clock);
    end
    check($sformatf("v%0d trig_count", idx), 64'(trig_count), 64'(exp_trig));
    check($sformatf("v%0d missed_count", idx), 64'(missed_count), 64'(exp_missed));
  endtask

  initial begin
    vt[0] = mk({8'd2, 8'd10, 8'd5, 8'd0}, {8'd0, 8'd4, 8'd3, 8'd1}, 0,  1, 0, 0,  1,  0, 0,  0, 0);
    vt[1] = mk({8'd2, 8'd10, 8'd5, 8'd0}, {8'd0, 8'd4, 8'd3, 8'd1}, 20, 1, 3, 20, 1,  0, 0,  0, 0);
    vt[2] = mk({8'd2, 8'd10, 8'd5, 8'd0}, {8'd0, 8'd4, 8'd3, 8'd1}, 0,  1, 0, 0,  1,  3, 50, 0, 2);
    vt[3] = mk({8'd2, 8'd10, 8'd50, 8'd0}, {8'd0, 8'd4, 8'd3, 8'd1}, 0, 1, 0, 0,  1,  0, 0,  0, 2);
    vt[4] = mk({8'd2, 8'd10, 8'd5, 8'd0}, {8'd0, 8'd4, 8'd3, 8'd1}, 0,  0, 3, 6,  1,  0, 0,  0, 2);
    vt[5] = mk({8'd1, 8'd0, 8'd7, 8'd3},  {8'd0, 8'd0, 8'd0, 8'd0}, 4,  1, 0, 0,  1,  0, 0,  0, 1);
    vt[6] = mk({8'd0, 8'd0, 8'd0, 8'd2},  {8'd0, 8'd0, 8'd0, 8'd2}, 3,  1, 0, 0,  30, 0, 0,  0, 2);
    vt[7] = mk({8'd0, 8'd0, 8'd0, 8'd0},  {8'd4, 8'd1, 8'd2, 8'd8}, 5,  1, 4, 0,  1,  0, 0,  2, 2);
    vt[8] = mk({8'd0, 8'd0, 8'd0, 8'd0},  {8'd1, 8'd0, 8'd0, 8'd0}, 0,  1, 0, 0,  1,  0, 0,  0, 1);

    trigger_in = 1'b0; arm = 1'b0; delay_cfg = '0; width_cfg = '0; holdoff_cfg = '0;
    s_trig = 1'b0; s_arm = 1'b1; s_delay = '0; s_width = '0; s_hold = '0;
    repeat (3) @(negedge clock);
    check("reset ch_out", 64'(ch_out), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset trig_count", 64'(trig_count), 64'd0);
    check("reset missed_count", 64'(missed_count), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 9; i++) run_vec(i);

    // arm raised while trigger is already high must wait for a fresh 0->1
    arm = 1'b0; trigger_in = 1'b1;
    repeat (3) @(negedge clock);
    arm = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("armhigh k%0d busy", k), 64'(busy), 64'd0);
    end
    check("armhigh trig_count", 64'(trig_count), 64'(exp_trig));
    trigger_in = 1'b0;
    @(negedge clock);
    trigger_in = 1'b1;
    @(negedge clock);
    exp_trig++;
    check("armhigh new edge busy", 64'(busy), 64'd1);
    check("armhigh new edge trig_count", 64'(trig_count), 64'(exp_trig));
    trigger_in = 1'b0;
    repeat (5) @(negedge clock);

    // reset in the middle of ch2's pulse
    delay_cfg = {24'd2, 24'd10, 24'd5, 24'd0};
    width_cfg = {24'd0, 24'd4, 24'd3, 24'd1};
    holdoff_cfg = '0; arm = 1'b1; trigger_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      trigger_in = 1'b0;
    end
    check("midpulse ch2 high", 64'(ch_out), 64'b0100);
    reset = 1'b1; trigger_in = 1'b1;
    #1;
    check("async reset ch_out", 64'(ch_out), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset trig_count", 64'(trig_count), 64'd0);
    check("async reset missed_count", 64'(missed_count), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      check($sformatf("post-reset k%0d ch_out/busy", k), 64'({ch_out, busy}), 64'd0);
    end
    check("post-reset trig_count", 64'(trig_count), 64'd0);
    trigger_in = 1'b0;
    @(negedge clock);
    trigger_in = 1'b1;
    @(negedge clock);
    trigger_in = 1'b0;
    check("post-reset edge busy", 64'(busy), 64'd1);
    check("post-reset edge trig_count", 64'(trig_count), 64'd1);
    repeat (20) @(negedge clock);

    // delay 15 + width 15 = 30 needs the extra elapsed-counter bit
    s_delay = 16'h000F; s_width = 16'h000F; s_hold = 4'd0; s_trig = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clock);
      s_trig = 1'b0;
      check($sformatf("wide k%0d ch0", k), 64'(s_ch), 64'((k > 15 && k <= 30) ? 1 : 0));
      check($sformatf("wide k%0d busy", k), 64'(s_busy), 64'((k <= 30) ? 1 : 0));
    end
    check("wide trig_count", 64'(s_tc), 64'd1);

    s_width = '0; s_hold = 4'd15; s_trig = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clock);
      s_trig = (k % 2 == 0) && (k <= 16);
    end
    check("missed saturation", 64'(s_mc), 64'd7);
    check("missed phase trig_count", 64'(s_tc), 64'd2);
    check("missed phase idle", 64'(s_busy), 64'd0);

    s_hold = 4'd0;
    for (int j = 0; j < 24; j++) begin
      @(negedge clock);
      s_trig = (j % 2 == 0);
    end
    s_trig = 1'b0;
    repeat (3) @(negedge clock);
    check("trig saturation", 64'(s_tc), 64'd7);
    check("missed held at max", 64'(s_mc), 64'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
